mem_stage: RTL

Memory-stage unit of the five-stage pipeline: the consuming end of the EX/MEM pipeline register. It takes the registered `mem_*` bundle, issues data-cache reads and writes and waits for `dhit`, stalling the upstream pipeline while it waits. It also resolves branch, jump and jump-register redirects and holds the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Shared widths for the pipeline and the data-cache port seen by the memory stage.
package cpu_types_pkg;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned JADR_W = 28;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;
endpackage

interface mem_stage_if;
    import cpu_types_pkg::*;

    logic  dhit;
    word_t dmemload;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;

    modport master (
        input  dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore
    );

    modport slave (
        output dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: data-cache access with stall, redirect resolution and the MEM/WB register.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    input  logic                mem_halt,
    input  logic                mem_RegWr,
    input  logic [1:0]          mem_MemtoReg,
    input  logic                mem_MemWr,
    input  logic                mem_MemRd,
    input  logic                mem_branch,
    input  logic                mem_zero,
    input  logic [1:0]          mem_PCSrc,
    input  logic [JADR_W-1:0]   mem_jump_addr,
    input  word_t               mem_pc_4,
    input  word_t               mem_branch_addr,
    input  word_t               mem_rdat1,
    input  word_t               mem_ex_out,
    input  word_t               mem_alu_out,
    input  word_t               mem_rdat2,
    input  word_t               mem_wsel,
    mem_stage_if.master         dcif,
    output logic                mem_stall,
    output logic                redirect,
    output word_t               npc,
    output logic                wb_RegWr,
    output logic                wb_halt,
    output regbits_t            wb_wsel,
    output word_t               wb_wdat
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ACCESS = 2'd1,
        HALT   = 2'd2
    } state_t;

    state_t state, state_next;
    word_t  wdat_sel;
    logic   taken;
    logic   mem_req;
    logic   unused_wsel_hi;

    assign unused_wsel_hi = ^mem_wsel[WORD_W-1:REG_W];
    assign mem_req        = mem_MemRd | mem_MemWr;

    assign dcif.dmemaddr  = mem_alu_out;
    assign dcif.dmemstore = mem_rdat2;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // RUN and ACCESS differ only in name: the held EX/MEM bundle keeps the request up.
    always_comb begin
        state_next   = state;
        dcif.dmemREN = 1'b0;
        dcif.dmemWEN = 1'b0;
        mem_stall    = 1'b0;
        unique case (state)
            RUN, ACCESS: begin
                dcif.dmemREN = mem_MemRd;
                dcif.dmemWEN = mem_MemWr;
                mem_stall    = mem_req & ~dcif.dhit;
                if (mem_stall) begin
                    state_next = ACCESS;
                end else if (mem_halt) begin
                    state_next = HALT;
                end else begin
                    state_next = RUN;
                end
            end
            HALT: begin
                mem_stall  = 1'b1;
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Control-transfer resolution; suppressed while the stage is frozen.
    always_comb begin
        taken = 1'b0;
        npc   = mem_pc_4;
        unique case (mem_PCSrc)
            2'b01: begin
                taken = (mem_zero == mem_branch);
                npc   = mem_branch_addr;
            end
            2'b10: begin
                taken = 1'b1;
                npc   = {mem_pc_4[WORD_W-1:JADR_W], mem_jump_addr};
            end
            2'b11: begin
                taken = 1'b1;
                npc   = mem_rdat1;
            end
            default: begin
                taken = 1'b0;
                npc   = mem_pc_4;
            end
        endcase
    end

    assign redirect = taken & ~mem_stall;

    always_comb begin
        wdat_sel = mem_alu_out;
        unique case (mem_MemtoReg)
            2'b00:   wdat_sel = mem_alu_out;
            2'b01:   wdat_sel = dcif.dmemload;
            2'b10:   wdat_sel = mem_pc_4;
            2'b11:   wdat_sel = mem_ex_out;
            default: wdat_sel = mem_alu_out;
        endcase
    end

    // MEM/WB: load when not stalled, bubble on a stall, freeze once halted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_RegWr <= 1'b0;
            wb_halt  <= 1'b0;
            wb_wsel  <= '0;
            wb_wdat  <= '0;
        end else if (state != HALT) begin
            if (!mem_stall) begin
                wb_RegWr <= mem_RegWr;
                wb_halt  <= mem_halt;
                wb_wsel  <= mem_wsel[REG_W-1:0];
                wb_wdat  <= wdat_sel;
            end else begin
                wb_RegWr <= 1'b0;
                wb_halt  <= 1'b0;
            end
        end
    end

endmodule
